// File: rtl/ddr_tx_pkg.sv
// ddr_tx_pkg: shared types, vendor target names and parameter checks
// for the DDR transmit serializer (and the matching receive side).
package ddr_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam string TGT_US       = "ULTRASCALE";
  localparam string TGT_USP      = "ULTRASCALE_PLUS";
  localparam string TGT_USP_ES1  = "ULTRASCALE_PLUS_ES1";
  localparam string TGT_USP_ES2  = "ULTRASCALE_PLUS_ES2";

  function automatic bit data_w_ok(input int w);
    return (w >= 2) && ((w % 2) == 0);
  endfunction

endpackage

// File: rtl/ddr_tx_serializer_oddr.sv
// oddr: one-pin DDR output cell; d1 in the high phase, d2 in the low.
// Ports: clk, rst_n, d1, d2, q. Macro DDR_TX_UNISIM enables ODDRE1.
module oddr
  import ddr_tx_pkg::*;
#(
  parameter string TARGET     = "ULTRASCALE",
  parameter logic  IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d1,
  input  logic d2,
  output logic q
);

  localparam bit VENDOR_TGT =
    (TARGET == TGT_US)      ||
    (TARGET == TGT_USP)     ||
    (TARGET == TGT_USP_ES1) ||
    (TARGET == TGT_USP_ES2);

  // The vendor primitive is only present when the
  // unisim library is compiled in.
`ifdef DDR_TX_UNISIM
  localparam bit HAVE_PRIM = 1'b1;
`else
  localparam bit HAVE_PRIM = 1'b0;
`endif

  localparam bit USE_VENDOR = VENDOR_TGT && HAVE_PRIM;

`ifdef DDR_TX_UNISIM
  if (USE_VENDOR) begin : g_vendor
    ODDRE1 #(
      .SRVAL      (IDLE_LEVEL),
      .SIM_DEVICE (TARGET)
    ) u_oddre1 (
      .C  (clk),
      .D1 (d1),
      .D2 (d2),
      .SR (!rst_n),
      .Q  (q)
    );
  end
`endif

  if (!USE_VENDOR) begin : g_fabric
    logic r1;
    logic r2p;
    logic r2n;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r1  <= IDLE_LEVEL;
        r2p <= IDLE_LEVEL;
      end else begin
        r1  <= d1;
        r2p <= d2;
      end
    end

    // d2 moves to a falling-edge flop so it is
    // stable for the whole low phase.
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) r2n <= IDLE_LEVEL;
      else        r2n <= r2p;
    end

    assign q = !rst_n ? IDLE_LEVEL
             : (clk ? r1 : r2n);
  end

endmodule

// File: rtl/ddr_tx_serializer.sv
// ddr_tx_serializer: valid/ready words out on one DDR pin, LSB first.
// Ports: s_data/s_valid/s_ready in, q/oe/busy out. Macro DDR_TX_TRAIN_EN.
module ddr_tx_serializer
  import ddr_tx_pkg::*;
#(
  parameter string TARGET     = "ULTRASCALE",
  parameter int    DATA_W     = 8,
  parameter logic  IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              q,
  output logic              oe,
  output logic              busy
);

  if (!data_w_ok(DATA_W)) begin : g_bad_w
    $error("ddr_tx_serializer: DATA_W must be even and >= 2");
  end

  localparam int NP = DATA_W / 2;
  localparam int CW = (NP > 1) ? $clog2(NP) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(NP - 1);

`ifdef DDR_TX_TRAIN_EN
  localparam logic IDLE_D1 = 1'b1;
  localparam logic IDLE_D2 = 1'b0;
`else
  localparam logic IDLE_D1 = IDLE_LEVEL;
  localparam logic IDLE_D2 = IDLE_LEVEL;
`endif

  state_t            state, state_n;
  logic              armed;
  logic [DATA_W-1:0] sh, sh_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              d1_q, d1_n;
  logic              d2_q, d2_n;
  logic              pvalid, pvalid_n;
  logic              oe_q;
  logic              accept;

  assign s_ready = armed &&
                   (state == IDLE || cnt == '0);
  assign accept  = s_valid && s_ready;
  assign busy    = (state == SHIFT);
  assign oe      = oe_q;

  always_comb begin
    state_n  = state;
    sh_n     = sh;
    cnt_n    = cnt;
    d1_n     = d1_q;
    d2_n     = d2_q;
    pvalid_n = pvalid;
    if (accept) begin
      d1_n     = s_data[0];
      d2_n     = s_data[1];
      sh_n     = s_data >> 2;
      cnt_n    = CNT_LOAD;
      pvalid_n = 1'b1;
      state_n  = SHIFT;
    end else if (state == SHIFT && cnt != '0) begin
      d1_n  = sh[0];
      d2_n  = sh[1];
      sh_n  = sh >> 2;
      cnt_n = cnt - 1'b1;
    end else if (state == SHIFT) begin
      d1_n     = IDLE_D1;
      d2_n     = IDLE_D2;
      pvalid_n = 1'b0;
      state_n  = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      armed  <= 1'b0;
      sh     <= '0;
      cnt    <= '0;
      d1_q   <= IDLE_D1;
      d2_q   <= IDLE_D2;
      pvalid <= 1'b0;
      oe_q   <= 1'b0;
    end else begin
      state  <= state_n;
      armed  <= 1'b1;
      sh     <= sh_n;
      cnt    <= cnt_n;
      d1_q   <= d1_n;
      d2_q   <= d2_n;
      pvalid <= pvalid_n;
      // Same edge the pin cell samples the pair,
      // so oe lines up with q.
      oe_q   <= pvalid;
    end
  end

  oddr #(
    .TARGET     (TARGET),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_oddr (
    .clk   (clk),
    .rst_n (rst_n),
    .d1    (d1_q),
    .d2    (d2_q),
    .q     (q)
  );

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// tb_ddr_tx_serializer: random and directed checks against a
// per-cycle timeline model of the expected DDR bitstream.
module tb_ddr_tx_serializer;

  localparam int W  = 8;
  localparam int NP = W / 2;

`ifdef DDR_TX_TRAIN_EN
  localparam logic [1:0] IDLE_PAIR = 2'b01;
`else
  localparam logic [1:0] IDLE_PAIR = 2'b00;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         q;
  logic         oe;
  logic         busy;

  ddr_tx_serializer #(
    .TARGET     ("ULTRASCALE"),
    .DATA_W     (W),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .q       (q),
    .oe      (oe),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int arm_cyc  = 1 << 30;
  int last_acc = -1000;

  // Expected pin contents per cycle: [0] high phase, [1] low phase.
  logic [1:0] tl_bits [int];
  bit         tl_oe   [int];

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Called at posedge+1 of cycle k; drives inputs for edge k+1
  // and checks everything the pin shows during cycle k.
  task automatic run_cycle(input logic v, input logic [W-1:0] d,
                           output logic [1:0] ob, output logic oo,
                           output bit acc);
    int k;
    bit er, eb, eo;
    logic [1:0] eq;
    k = cyc;
    s_valid = v;
    s_data  = d;
    er = (k >= arm_cyc) && (k >= last_acc + NP - 1);
    eb = (k >= last_acc) && (k <= last_acc + NP - 1);
    eq = tl_bits.exists(k) ? tl_bits[k] : IDLE_PAIR;
    eo = tl_oe.exists(k) ? tl_oe[k] : 1'b0;
    #1;
    total++;
    if (s_ready !== er) begin
      bad++;
      $display("FAIL s_ready cyc=%0d got %b want %b", k, s_ready, er);
    end
    total++;
    if (busy !== eb) begin
      bad++;
      $display("FAIL busy cyc=%0d got %b want %b", k, busy, eb);
    end
    ob[0] = q;
    oo = oe;
    total++;
    if (q !== eq[0] || oe !== eo) begin
      bad++;
      $display("FAIL q_hi cyc=%0d got q=%b oe=%b want q=%b oe=%b",
               k, q, oe, eq[0], eo);
    end
    @(negedge clk);
    #2;
    ob[1] = q;
    total++;
    if (q !== eq[1] || oe !== eo) begin
      bad++;
      $display("FAIL q_lo cyc=%0d got q=%b oe=%b want q=%b oe=%b",
               k, q, oe, eq[1], eo);
    end
    acc = v && er;
    if (acc) begin
      last_acc = k + 1;
      for (int j = 0; j < NP; j++) begin
        tl_bits[k + 2 + j] = d[2*j +: 2];
        tl_oe[k + 2 + j]   = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    logic [1:0] b;
    logic o;
    bit a;
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, b, o, a);
  endtask

  task automatic release_reset(input int hold);
    tl_bits.delete();
    tl_oe.delete();
    last_acc = -1000;
    arm_cyc  = 1 << 30;
    for (int i = 0; i < hold; i++) tick();
    rst_n = 1'b1;
    arm_cyc = cyc + 1;
    tl_bits[cyc] = 2'b00;
  endtask

  task automatic test_reset();
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (q !== 1'b0 || oe !== 1'b0 ||
          s_ready !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold got q=%b oe=%b rdy=%b busy=%b want 0000",
                 q, oe, s_ready, busy);
      end
    end
    release_reset(0);
    idle(3);
  endtask

  task automatic test_single_word();
    logic [1:0] b;
    logic o;
    bit a;
    logic [W-1:0] st;
    int ones;
    run_cycle(1'b1, 8'hA5, b, o, a);
    total++;
    if (!a) begin
      bad++;
      $display("FAIL single_accept got %b want 1", a);
    end
    run_cycle(1'b0, '0, b, o, a);
    st = '0;
    ones = 0;
    for (int i = 0; i < NP; i++) begin
      run_cycle(1'b0, '0, b, o, a);
      st[2*i +: 2] = b;
      if (o) ones++;
    end
    total++;
    if (st !== 8'hA5 || ones != NP) begin
      bad++;
      $display("FAIL single_stream got %h oe=%0d want a5 oe=%0d",
               st, ones, NP);
    end
    run_cycle(1'b0, '0, b, o, a);
    total++;
    if (o !== 1'b0) begin
      bad++;
      $display("FAIL single_oe_end got %b want 0", o);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] b;
    logic o;
    bit a, a1, a2;
    logic [2*W-1:0] st;
    int ones;
    run_cycle(1'b1, 8'h3C, b, o, a1);
    st = '0;
    ones = 0;
    a2 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_cycle(i < 4, 8'hC3, b, o, a);
      if (i == 3) a2 = a;
      if (i >= 1) begin
        st[2*(i-1) +: 2] = b;
        if (o) ones++;
      end
    end
    total++;
    if (!a1 || !a2 || st !== 16'hC33C || ones != 8) begin
      bad++;
      $display("FAIL b2b got acc=%b%b bits=%h oe=%0d want 11 c33c 8",
               a1, a2, st, ones);
    end
  endtask

  task automatic test_stall();
    logic [1:0] b;
    logic o;
    bit a, a1, a2;
    logic [W-1:0] wa, wb;
    logic [2*W-1:0] st;
    int nb, gap;
    wa = W'($urandom);
    wb = W'($urandom);
    run_cycle(1'b1, wa, b, o, a1);
    st = '0;
    nb = 0;
    gap = 0;
    a2 = 1'b0;
    for (int i = 0; i < 13; i++) begin
      run_cycle(i == 6, wb, b, o, a);
      if (i == 6) a2 = a;
      if (o && nb < 2*NP) begin
        st[2*nb +: 2] = b;
        nb++;
      end else if (nb == NP) begin
        gap++;
      end
    end
    total++;
    if (!a1 || !a2 || gap != 3 || nb != 2*NP || st !== {wb, wa}) begin
      bad++;
      $display("FAIL stall got acc=%b%b gap=%0d bits=%h want 11 3 %h",
               a1, a2, gap, st, {wb, wa});
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] b;
    logic o;
    bit a, a1;
    logic [W-1:0] st;
    run_cycle(1'b1, 8'hFF, b, o, a);
    idle(2);
    rst_n = 1'b0;
    s_valid = 1'b0;
    #1;
    total++;
    if (q !== 1'b0 || oe !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got q=%b oe=%b busy=%b want 000",
               q, oe, busy);
    end
    #1;
    release_reset(2);
    run_cycle(1'b0, '0, b, o, a);
    run_cycle(1'b1, 8'h01, b, o, a1);
    run_cycle(1'b0, '0, b, o, a);
    st = '0;
    for (int i = 0; i < NP; i++) begin
      run_cycle(1'b0, '0, b, o, a);
      st[2*i +: 2] = b;
    end
    total++;
    if (!a1 || st !== 8'h01) begin
      bad++;
      $display("FAIL after_reset got acc=%b bits=%h want 1 01", a1, st);
    end
    idle(2);
  endtask

  task automatic test_random();
    logic [1:0] b;
    logic o;
    bit a;
    int nacc;
    nacc = 0;
    for (int i = 0; i < 300; i++) begin
      run_cycle($urandom_range(0, 3) != 0, W'($urandom), b, o, a);
      if (a) nacc++;
    end
    idle(NP + 2);
    total++;
    if (nacc < 40) begin
      bad++;
      $display("FAIL random_accepts got %0d want >=40", nacc);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
